// File: rtl/bcp_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : bcp_engine
//  Purpose  : Boolean constraint propagation over the clauses that contain
//             the newly falsified literal; pushes unit implications, flags
//             conflicts.
//  Revision : 1.0  initial release
// ============================================================================
module bcp_engine #(
    parameter int NUM_VARIABLE   = 128,
    parameter int VARIABLE_INDEX = 7,
    parameter int VAR_PER_CLAUSE = 5,
    parameter int CLAUSE_INDEX   = 9
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         i_start,
    input  logic [VARIABLE_INDEX-1:0]                    i_prop_var,
    input  logic                                         i_prop_val,
    output logic                                         o_range_req,
    output logic [VARIABLE_INDEX-1:0]                    o_range_var,
    output logic                                         o_range_neg,
    input  logic [CLAUSE_INDEX-1:0]                      i_range_start,
    input  logic [CLAUSE_INDEX-1:0]                      i_range_end,
    output logic                                         o_clause_rd,
    output logic [CLAUSE_INDEX-1:0]                      o_clause_addr,
    input  logic [VAR_PER_CLAUSE*(VARIABLE_INDEX+2)-1:0] i_clause_data,
    input  logic [NUM_VARIABLE-1:0]                      i_assigned,
    input  logic [NUM_VARIABLE-1:0]                      i_assign_val,
    output logic                                         o_imply_push,
    output logic [VARIABLE_INDEX-1:0]                    o_imply_var,
    output logic                                         o_imply_val,
    input  logic                                         i_imply_full,
    output logic                                         o_busy,
    output logic                                         o_done,
    output logic                                         o_conflict
);

    localparam int c_lit_w    = VARIABLE_INDEX + 2;
    localparam int c_clause_w = VAR_PER_CLAUSE * c_lit_w;
    localparam int c_cnt_w    = $clog2(VAR_PER_CLAUSE + 1);
    localparam logic [c_cnt_w-1:0]      c_cnt_one  = 1;
    localparam logic [CLAUSE_INDEX-1:0] c_addr_one = 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RANGE      = 3'd1,
        S_RANGE_WAIT = 3'd2,
        S_FETCH      = 3'd3,
        S_EVAL       = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [VARIABLE_INDEX-1:0]   r_var;
    logic                        r_val;
    logic [CLAUSE_INDEX-1:0]     r_end;
    logic [CLAUSE_INDEX-1:0]     r_addr;
    logic [c_clause_w-1:0]       r_clause;
    logic                        r_first;
    logic                        r_conflict;
    logic                        r_push;
    logic [VARIABLE_INDEX-1:0]   r_imply_var;
    logic                        r_imply_val;

    logic [c_clause_w-1:0]       w_clause;
    logic [VAR_PER_CLAUSE-1:0]   w_slot_true;
    logic [VAR_PER_CLAUSE-1:0]   w_slot_unas;
    logic [VARIABLE_INDEX-1:0]   w_slot_var [VAR_PER_CLAUSE];
    logic [VAR_PER_CLAUSE-1:0]   w_slot_neg;
    logic                        w_sat;
    logic [c_cnt_w-1:0]          w_n_unas;
    logic [VARIABLE_INDEX-1:0]   w_unit_var;
    logic                        w_unit_neg;
    logic                        w_cls_conflict;
    logic                        w_cls_unit;
    logic [CLAUSE_INDEX-1:0]     w_addr_nxt;
    logic                        w_last;

    // Memory data is only valid on the first EVAL cycle; stalls use the copy.
    assign w_clause = r_first ? i_clause_data : r_clause;

    for (genvar g = 0; g < VAR_PER_CLAUSE; g++) begin : g_slot
        logic [c_lit_w-1:0]        w_lit;
        logic [VARIABLE_INDEX-1:0] w_var;
        assign w_lit          = w_clause[g*c_lit_w +: c_lit_w];
        assign w_var          = w_lit[VARIABLE_INDEX-1:0];
        assign w_slot_true[g] = w_lit[c_lit_w-1] && i_assigned[w_var]
                                && (i_assign_val[w_var] != w_lit[VARIABLE_INDEX]);
        assign w_slot_unas[g] = w_lit[c_lit_w-1] && !i_assigned[w_var];
        assign w_slot_var[g]  = w_var;
        assign w_slot_neg[g]  = w_lit[VARIABLE_INDEX];
    end

    assign w_sat = |w_slot_true;

    always_comb begin
        w_n_unas   = '0;
        w_unit_var = '0;
        w_unit_neg = 1'b0;
        for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
            if (w_slot_unas[i]) begin
                w_n_unas   = w_n_unas + c_cnt_one;
                w_unit_var = w_slot_var[i];
                w_unit_neg = w_slot_neg[i];
            end
        end
    end

    assign w_cls_conflict = !w_sat && (w_n_unas == '0);
    assign w_cls_unit     = !w_sat && (w_n_unas == c_cnt_one);
    assign w_addr_nxt     = r_addr + c_addr_one;
    assign w_last         = (w_addr_nxt == r_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_range_req = 1'b0;
        o_clause_rd = 1'b0;
        o_done      = 1'b0;
        o_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RANGE;
                end
            end
            S_RANGE: begin
                o_range_req = 1'b1;
                w_state_nxt = S_RANGE_WAIT;
            end
            S_RANGE_WAIT: begin
                w_state_nxt = (i_range_start == i_range_end) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                o_clause_rd = 1'b1;
                w_state_nxt = S_EVAL;
            end
            S_EVAL: begin
                if (w_cls_conflict) begin
                    w_state_nxt = S_DONE;
                end else if (w_cls_unit && i_imply_full) begin
                    w_state_nxt = S_EVAL;
                end else begin
                    w_state_nxt = w_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_var       <= '0;
            r_val       <= 1'b0;
            r_end       <= '0;
            r_addr      <= '0;
            r_clause    <= '0;
            r_first     <= 1'b0;
            r_conflict  <= 1'b0;
            r_push      <= 1'b0;
            r_imply_var <= '0;
            r_imply_val <= 1'b0;
        end else begin
            r_push <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_var      <= i_prop_var;
                        r_val      <= i_prop_val;
                        r_conflict <= 1'b0;
                    end
                end
                S_RANGE_WAIT: begin
                    r_end  <= i_range_end;
                    r_addr <= i_range_start;
                end
                S_FETCH: begin
                    r_first <= 1'b1;
                end
                S_EVAL: begin
                    r_first <= 1'b0;
                    if (r_first) begin
                        r_clause <= i_clause_data;
                    end
                    if (w_cls_conflict) begin
                        r_conflict <= 1'b1;
                    end else if (!(w_cls_unit && i_imply_full)) begin
                        if (w_cls_unit) begin
                            r_push      <= 1'b1;
                            r_imply_var <= w_unit_var;
                            r_imply_val <= ~w_unit_neg;
                        end
                        r_addr <= w_addr_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_range_var   = r_var;
    assign o_range_neg   = r_val;
    assign o_clause_addr = r_addr;
    assign o_imply_push  = r_push;
    assign o_imply_var   = r_imply_var;
    assign o_imply_val   = r_imply_val;
    assign o_conflict    = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_bcp_engine.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for bcp_engine: a clause-walk model builds the expected
// per-cycle trace of each run; literal totals per run pin the model.
module tb_bcp_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start;
    logic [6:0]   i_prop_var;
    logic         i_prop_val;
    logic         o_range_req;
    logic [6:0]   o_range_var;
    logic         o_range_neg;
    logic [8:0]   i_range_start;
    logic [8:0]   i_range_end;
    logic         o_clause_rd;
    logic [8:0]   o_clause_addr;
    logic [44:0]  i_clause_data;
    logic [127:0] assigned;
    logic [127:0] assign_val;
    logic         o_imply_push;
    logic [6:0]   o_imply_var;
    logic         o_imply_val;
    logic         i_imply_full;
    logic         o_busy;
    logic         o_done;
    logic         o_conflict;

    bcp_engine dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_prop_var(i_prop_var), .i_prop_val(i_prop_val),
        .o_range_req(o_range_req), .o_range_var(o_range_var), .o_range_neg(o_range_neg),
        .i_range_start(i_range_start), .i_range_end(i_range_end),
        .o_clause_rd(o_clause_rd), .o_clause_addr(o_clause_addr), .i_clause_data(i_clause_data),
        .i_assigned(assigned), .i_assign_val(assign_val),
        .o_imply_push(o_imply_push), .o_imply_var(o_imply_var), .o_imply_val(o_imply_val),
        .i_imply_full(i_imply_full),
        .o_busy(o_busy), .o_done(o_done), .o_conflict(o_conflict)
    );

    always #5 clk = ~clk;

    logic [44:0] cmem [512];

    // Data is only valid the cycle after a read; otherwise a junk word
    // (five unassigned x127 literals) so a non-latching engine misbehaves.
    always @(posedge clk) begin
        i_clause_data <= o_clause_rd ? cmem[o_clause_addr] : {45{1'b1}};
    end

    int n_vec  = 0;
    int n_miss = 0;

    bit exp_busy [64], exp_done [64], exp_rreq [64], exp_crd [64];
    bit exp_push [64], exp_ival [64], exp_conf [64], exp_full [64], exp_rstz [64];
    int exp_addr [64], exp_ivar [64];
    int exp_rv;
    bit exp_rn;

    bit active = 1'b0;
    int cur_t  = 0;
    int obs_done, obs_push, obs_var, obs_val;

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, t, act, expv);
        end
    endtask

    function automatic logic [8:0] lit(input bit neg, input int v);
        return {1'b1, neg, v[6:0]};
    endfunction

    function automatic logic [44:0] cl(input logic [8:0] a, input logic [8:0] b,
                                       input logic [8:0] c, input logic [8:0] d,
                                       input logic [8:0] e);
        return {e, d, c, b, a};
    endfunction

    function automatic void classify(input logic [44:0] w, output bit sat, output int nun,
                                     output int uv, output bit uval);
        logic [8:0] l;
        sat = 0; nun = 0; uv = 0; uval = 0;
        for (int i = 0; i < 5; i++) begin
            l = w[i*9 +: 9];
            if (l[8]) begin
                if (assigned[l[6:0]]) begin
                    if (assign_val[l[6:0]] != l[7]) sat = 1;
                end else begin
                    nun++;
                    uv   = int'(l[6:0]);
                    uval = ~l[7];
                end
            end
        end
    endfunction

    // Walk the clause list as the algorithm describes and lay out the trace.
    task automatic build(input int pv, input bit pval, input int s, input int e,
                         input int stall, input int rst_t, output int len);
        int t, a, nun, uv, stl;
        bit conf, sat, uval;
        for (int i = 0; i < 64; i++) begin
            exp_busy[i] = 0; exp_done[i] = 0; exp_rreq[i] = 0; exp_crd[i] = 0;
            exp_push[i] = 0; exp_ival[i] = 0; exp_conf[i] = 0; exp_full[i] = 0;
            exp_rstz[i] = 0; exp_addr[i] = 0; exp_ivar[i] = 0;
        end
        exp_rv = pv; exp_rn = pval;
        exp_rreq[1] = 1;
        t = 3; conf = 0; stl = stall; a = s;
        while (a != e && !conf) begin
            exp_crd[t] = 1; exp_addr[t] = a; t++;
            classify(cmem[a], sat, nun, uv, uval);
            if (!sat && nun == 0) begin
                conf = 1;
            end else if (!sat && nun == 1) begin
                for (int j = 0; j < stl; j++) begin exp_full[t] = 1; t++; end
                stl = 0;
                exp_push[t+1] = 1; exp_ivar[t+1] = uv; exp_ival[t+1] = uval;
            end
            t++;
            a = (a + 1) % 512;
        end
        exp_done[t] = 1;
        for (int u = 1; u <= t; u++) exp_busy[u] = 1;
        for (int u = t; u < 64; u++) exp_conf[u] = conf;
        len = t + 2;
        if (rst_t > 0) begin
            for (int u = rst_t + 1; u < 64; u++) begin
                exp_busy[u] = 0; exp_done[u] = 0; exp_rreq[u] = 0; exp_crd[u] = 0;
                exp_push[u] = 0; exp_conf[u] = 0; exp_full[u] = 0; exp_rstz[u] = 1;
            end
            len = rst_t + 3;
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            chk("busy",      cur_t, o_busy,      exp_busy[cur_t]);
            chk("done",      cur_t, o_done,      exp_done[cur_t]);
            chk("range_req", cur_t, o_range_req, exp_rreq[cur_t]);
            chk("clause_rd", cur_t, o_clause_rd, exp_crd[cur_t]);
            chk("push",      cur_t, o_imply_push, exp_push[cur_t]);
            chk("conflict",  cur_t, o_conflict,  exp_conf[cur_t]);
            if (exp_busy[cur_t]) begin
                chk("range_var", cur_t, o_range_var, exp_rv);
                chk("range_neg", cur_t, o_range_neg, exp_rn);
            end
            if (exp_crd[cur_t])  chk("clause_addr", cur_t, o_clause_addr, exp_addr[cur_t]);
            if (exp_push[cur_t]) begin
                chk("imply_var", cur_t, o_imply_var, exp_ivar[cur_t]);
                chk("imply_val", cur_t, o_imply_val, exp_ival[cur_t]);
            end
            if (exp_rstz[cur_t]) begin
                chk("rst_addr",      cur_t, o_clause_addr, 0);
                chk("rst_range_var", cur_t, o_range_var,   0);
                chk("rst_imply_var", cur_t, o_imply_var,   0);
            end
            if (o_imply_push && i_imply_full) chk("push_while_full", cur_t, 1, 0);
            if (o_done && obs_done == 0) obs_done = cur_t;
            if (o_imply_push) begin
                obs_push++;
                obs_var = int'(o_imply_var);
                obs_val = int'(o_imply_val);
            end
        end
    end

    task automatic run(input int pv, input bit pval, input int s, input int e,
                       input int stall, input int rst_t, input int busy_start_t,
                       input int l_done, input int l_push, input int l_var,
                       input int l_val, input bit l_conf);
        int len;
        build(pv, pval, s, e, stall, rst_t, len);
        obs_done = 0; obs_push = 0; obs_var = 0; obs_val = 0;
        @(negedge clk);
        i_prop_var = pv[6:0]; i_prop_val = pval; i_start = 1'b1;
        i_range_start = s[8:0]; i_range_end = e[8:0];
        @(posedge clk);
        for (int t = 1; t <= len; t++) begin
            #1;
            i_start = (t == busy_start_t);
            if (t == busy_start_t) begin i_prop_var = 7'd55; i_prop_val = 1'b0; end
            i_imply_full = exp_full[t];
            rst_n = (t != rst_t);
            cur_t = t; active = 1'b1;
            @(posedge clk);
        end
        #1;
        active = 1'b0; rst_n = 1'b1; i_start = 1'b0; i_imply_full = 1'b0;
        chk("done_cycle",   0, obs_done, l_done);
        chk("push_count",   0, obs_push, l_push);
        chk("last_push_var", 0, obs_var, l_var);
        chk("last_push_val", 0, obs_val, l_val);
        chk("final_conflict", 0, o_conflict, l_conf);
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_prop_var = '0; i_prop_val = 1'b0;
        i_range_start = '0; i_range_end = '0; i_imply_full = 1'b0;
        assigned = '0; assign_val = '0;
        assigned[3] = 1'b1; assign_val[3] = 1'b0;
        assigned[7] = 1'b1; assign_val[7] = 1'b1;
        for (int i = 0; i < 512; i++) cmem[i] = '0;
        cmem[10] = cl(lit(1, 3), lit(0, 60), 9'd0, 9'd0, 9'd0);
        cmem[11] = cl(lit(0, 3), lit(1, 7), 9'd0, 9'd0, lit(0, 9));
        cmem[12] = cl(lit(1, 7), lit(0, 20), lit(0, 21), 9'd0, 9'd0);
        cmem[20] = cl(lit(1, 3), 9'd0, 9'd0, 9'd0, 9'd0);
        cmem[21] = cl(lit(0, 3), lit(1, 7), 9'd0, 9'd0, 9'd0);
        cmem[22] = cl(lit(1, 7), lit(0, 30), 9'd0, 9'd0, 9'd0);
        cmem[23] = cl(lit(1, 31), 9'd0, lit(0, 3), 9'd0, 9'd0);
        cmem[30] = cl(lit(1, 7), lit(0, 40), lit(0, 3), 9'd0, 9'd0);
        cmem[31] = cl(lit(0, 7), 9'd0, 9'd0, 9'd0, 9'd0);
        cmem[40] = cl(lit(1, 3), lit(0, 50), lit(0, 51), 9'd0, 9'd0);
        cmem[41] = cl(lit(0, 50), lit(1, 51), lit(0, 3), 9'd0, 9'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",      0, o_busy,        0);
        chk("reset_done",      0, o_done,        0);
        chk("reset_conflict",  0, o_conflict,    0);
        chk("reset_range_req", 0, o_range_req,   0);
        chk("reset_clause_rd", 0, o_clause_rd,   0);
        chk("reset_push",      0, o_imply_push,  0);
        chk("reset_addr",      0, o_clause_addr, 0);
        chk("reset_range_var", 0, o_range_var,   0);
        chk("reset_imply_var", 0, o_imply_var,   0);
        rst_n = 1'b1;
        @(negedge clk);

        //  pv pval  s   e stall rst bst done push var val conf
        run(1, 1,   5,  5, 0, 0, 0, 3, 0,  0, 0, 0);   // empty range
        run(7, 1,  10, 13, 0, 0, 0, 9, 1,  9, 1, 0);   // one unit in three
        run(7, 1,  20, 24, 0, 0, 0, 7, 0,  0, 0, 1);   // conflict on clause 2
        run(7, 1,  40, 42, 0, 0, 0, 7, 0,  0, 0, 0);   // sat/skip, conflict clears
        run(7, 1,  30, 32, 2, 0, 0, 9, 1, 40, 1, 0);   // 2-cycle full stall
        run(7, 1,  22, 24, 0, 0, 0, 7, 2, 31, 0, 0);   // back-to-back pushes
        run(7, 1,  10, 13, 0, 6, 0, 0, 0,  0, 0, 0);   // reset mid-EVAL
        run(7, 1,  10, 13, 0, 0, 4, 9, 1,  9, 1, 0);   // start while busy

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
